fir_tap_sequencer: RTL

- Drives the transposed FIR multiply/accumulate datapath. It is the source side of that datapath's sample/coefficient/enable interface.
- Divides the 12 MHz clock into the 300 kHz sample strobe and latches each new input sample.
- Walks the coefficient bank tap by tap, issuing one coefficient per cycle with the matching multiply, add and accumulate enables.
- Owns the writable coefficient bank that the control bus loads.

---
 rtl/fir_pkg.sv | 18 +
 rtl/fir_tap_sequencer_if.sv | 31 +++
 rtl/fir_coeff_bank.sv | 89 ++++++++
 rtl/fir_tap_sequencer.sv | 121 ++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared constants and types for the FIR tap sequencer.
// Default sizes, tap-index width and the sequencer state encoding.
package fir_pkg;

  localparam int unsigned DEF_CLK_DIV  = 40;
  localparam int unsigned DEF_NUM_TAPS = 10;
  localparam int unsigned DEF_DATA_W   = 16;
  localparam int unsigned DEF_COEFF_W  = 16;

  localparam int unsigned TAP_IDX_W = 4;

  typedef enum logic [1:0] {
    StIdle,
    StTap,
    StAcc
  } fir_state_e;

endpackage

// File: rtl/fir_tap_sequencer_if.sv
// Sequencer-to-datapath signals plus the coefficient write bus.
// The sequencer uses the master modport; the datapath/control side uses slave.
interface fir_tap_sequencer_if #(
  parameter int unsigned DATA_W  = fir_pkg::DEF_DATA_W,
  parameter int unsigned COEFF_W = fir_pkg::DEF_COEFF_W
) ();

  logic                              oEnSample_300k;
  logic signed [DATA_W-1:0]          oFirIn;
  logic signed [COEFF_W-1:0]         oCoeff;
  logic [fir_pkg::TAP_IDX_W-1:0]     oEnMul;
  logic                              oEnAdd;
  logic                              oEnAcc;
  logic                              oBusy;

  logic                              iCoeffWrEn;
  logic [fir_pkg::TAP_IDX_W-1:0]     iCoeffWrAddr;
  logic signed [COEFF_W-1:0]         iCoeffWrData;
  logic                              oCoeffWrErr;

  modport master (
    output oEnSample_300k, oFirIn, oCoeff, oEnMul, oEnAdd, oEnAcc, oBusy, oCoeffWrErr,
    input  iCoeffWrEn, iCoeffWrAddr, iCoeffWrData
  );

  modport slave (
    input  oEnSample_300k, oFirIn, oCoeff, oEnMul, oEnAdd, oEnAcc, oBusy, oCoeffWrErr,
    output iCoeffWrEn, iCoeffWrAddr, iCoeffWrData
  );

endinterface

// File: rtl/fir_coeff_bank.sv
// Writable coefficient bank (taps 1..NUM_TAPS) with write-legality check.
// FIR_COEFF_SHADOW_EN adds a shadow bank copied into the active bank on the strobe.
module fir_coeff_bank
  import fir_pkg::*;
#(
  parameter int unsigned NUM_TAPS = DEF_NUM_TAPS,
  parameter int unsigned COEFF_W  = DEF_COEFF_W
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      strobe_i,
  input  logic                      lock_i,
  input  logic                      wr_en_i,
  input  logic [TAP_IDX_W-1:0]      wr_addr_i,
  input  logic signed [COEFF_W-1:0] wr_data_i,
  input  logic [TAP_IDX_W-1:0]      rd_addr_i,
  output logic signed [COEFF_W-1:0] rd_data_o,
  output logic                      wr_err_o
);

  logic addr_ok;
  logic wr_lock;
  logic wr_accept;
  logic wr_err_q;

  assign addr_ok   = (wr_addr_i != '0) && (wr_addr_i <= TAP_IDX_W'(NUM_TAPS));
  assign wr_accept = wr_en_i && addr_ok && !wr_lock;
  assign wr_err_o  = wr_err_q;

`ifdef FIR_COEFF_SHADOW_EN
  logic signed [COEFF_W-1:0] shadow_q [1:NUM_TAPS];
  logic signed [COEFF_W-1:0] active_q [1:NUM_TAPS];

  assign wr_lock = lock_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 1; i <= NUM_TAPS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      for (int i = 1; i <= NUM_TAPS; i++) begin
        if (wr_accept && (wr_addr_i == TAP_IDX_W'(i))) shadow_q[i] <= wr_data_i;
        // Copy takes the pre-write shadow, so a strobe-cycle write waits a sample.
        if (strobe_i) active_q[i] <= shadow_q[i];
      end
    end
  end

  // On the strobe the first tap must already see the bank being copied in.
  always_comb begin
    rd_data_o = '0;
    for (int i = 1; i <= NUM_TAPS; i++) begin
      if (rd_addr_i == TAP_IDX_W'(i)) rd_data_o = strobe_i ? shadow_q[i] : active_q[i];
    end
  end
`else
  logic signed [COEFF_W-1:0] bank_q [1:NUM_TAPS];

  assign wr_lock = lock_i || strobe_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 1; i <= NUM_TAPS; i++) bank_q[i] <= '0;
    end else begin
      for (int i = 1; i <= NUM_TAPS; i++) begin
        if (wr_accept && (wr_addr_i == TAP_IDX_W'(i))) bank_q[i] <= wr_data_i;
      end
    end
  end

  always_comb begin
    rd_data_o = '0;
    for (int i = 1; i <= NUM_TAPS; i++) begin
      if (rd_addr_i == TAP_IDX_W'(i)) rd_data_o = bank_q[i];
    end
  end
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_err_q <= 1'b0;
    end else begin
      wr_err_q <= wr_en_i && (!addr_ok || wr_lock);
    end
  end

endmodule

// File: rtl/fir_tap_sequencer.sv
// Sample-rate divider and tap FSM feeding the transposed FIR MAC datapath.
// Optional macro FIR_COEFF_SHADOW_EN selects double-buffered coefficient writes.
module fir_tap_sequencer
  import fir_pkg::*;
#(
  parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
  parameter int unsigned NUM_TAPS = DEF_NUM_TAPS,
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned COEFF_W  = DEF_COEFF_W
) (
  input  logic                     iClk_12M,
  input  logic                     iRst,
  input  logic signed [DATA_W-1:0] iSample,
  fir_tap_sequencer_if.master      bus_io
);

  logic [15:0]               div_cnt_q, div_cnt_d;
  logic                      strobe;

  fir_state_e                state_q, state_d;
  logic [TAP_IDX_W-1:0]      tap_q, tap_d;
  logic signed [DATA_W-1:0]  fir_in_q, fir_in_d;
  logic signed [COEFF_W-1:0] coeff_q, coeff_d;
  logic                      acc_q, acc_d;

  logic signed [COEFF_W-1:0] rd_coeff;
  logic                      coeff_wr_lock;

  // Divider
  assign strobe    = (div_cnt_q == 16'(CLK_DIV - 1));
  assign div_cnt_d = strobe ? '0 : div_cnt_q + 16'd1;

  always_ff @(posedge iClk_12M or posedge iRst) begin
    if (iRst) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

  // Tap FSM; tap_d doubles as the bank read address for the next cycle's tap
  always_comb begin
    state_d  = state_q;
    tap_d    = tap_q;
    fir_in_d = fir_in_q;
    acc_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (strobe) begin
          state_d  = StTap;
          tap_d    = TAP_IDX_W'(1);
          fir_in_d = iSample;
        end
      end
      StTap: begin
        if (tap_q == TAP_IDX_W'(NUM_TAPS)) begin
          state_d = StAcc;
          tap_d   = '0;
          acc_d   = 1'b1;
        end else begin
          tap_d = tap_q + TAP_IDX_W'(1);
        end
      end
      StAcc: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        tap_d   = '0;
      end
    endcase
    coeff_d = (tap_d != '0) ? rd_coeff : coeff_q;
  end

  always_ff @(posedge iClk_12M or posedge iRst) begin
    if (iRst) begin
      state_q  <= StIdle;
      tap_q    <= '0;
      fir_in_q <= '0;
      coeff_q  <= '0;
      acc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tap_q    <= tap_d;
      fir_in_q <= fir_in_d;
      coeff_q  <= coeff_d;
      acc_q    <= acc_d;
    end
  end

`ifdef FIR_COEFF_SHADOW_EN
  assign coeff_wr_lock = 1'b0;
`else
  assign coeff_wr_lock = (state_q != StIdle);
`endif

  fir_coeff_bank #(
    .NUM_TAPS (NUM_TAPS),
    .COEFF_W  (COEFF_W)
  ) u_coeff_bank (
    .clk_i     (iClk_12M),
    .rst_i     (iRst),
    .strobe_i  (strobe),
    .lock_i    (coeff_wr_lock),
    .wr_en_i   (bus_io.iCoeffWrEn),
    .wr_addr_i (bus_io.iCoeffWrAddr),
    .wr_data_i (bus_io.iCoeffWrData),
    .rd_addr_i (tap_d),
    .rd_data_o (rd_coeff),
    .wr_err_o  (bus_io.oCoeffWrErr)
  );

  assign bus_io.oEnSample_300k = strobe;
  assign bus_io.oFirIn         = fir_in_q;
  assign bus_io.oCoeff         = coeff_q;
  assign bus_io.oEnMul         = tap_q;
  assign bus_io.oEnAdd         = (tap_q >= TAP_IDX_W'(2));
  assign bus_io.oEnAcc         = acc_q;
  assign bus_io.oBusy          = strobe || (state_q != StIdle);

endmodule
